// File: rtl/tt_sweep_capture_if.sv
// Bus between the truth-table sweeper and the function under test / result consumer.
// TT_SWEEP_COMPARE_EN adds the reference table input and the match result.
interface tt_sweep_capture_if #(
  parameter int unsigned N_INPUTS = 7
);
  localparam int unsigned TT_W = 1 << N_INPUTS;

  logic                start;
  logic                f_in;
  logic                busy;
  logic                done;
  logic [N_INPUTS-1:0] x_out;
  logic [TT_W-1:0]     tt_out;
  logic [N_INPUTS:0]   ones_count;
`ifdef TT_SWEEP_COMPARE_EN
  logic [TT_W-1:0]     expected_tt;
  logic                match;

  modport master (
    input  start, f_in, expected_tt,
    output x_out, busy, done, tt_out, ones_count, match
  );
  modport slave (
    output start, f_in, expected_tt,
    input  x_out, busy, done, tt_out, ones_count, match
  );
`else
  modport master (
    input  start, f_in,
    output x_out, busy, done, tt_out, ones_count
  );
  modport slave (
    output start, f_in,
    input  x_out, busy, done, tt_out, ones_count
  );
`endif
endinterface

// File: rtl/tt_sweep_capture.sv
// Drives every input vector onto a combinational function and captures its truth table
// and on-set weight. Optional reference comparison under TT_SWEEP_COMPARE_EN.
module tt_sweep_capture #(
  parameter int unsigned N_INPUTS = 7,
  parameter int unsigned SETTLE   = 0
) (
  input logic              clk,
  input logic              rst_n,
  tt_sweep_capture_if.master bus
);
  localparam int unsigned         TT_W        = 1 << N_INPUTS;
  localparam bit                  HAS_SETTLE  = (SETTLE != 0);
  localparam logic [3:0]          SETTLE_LAST = HAS_SETTLE ? 4'(SETTLE - 1) : 4'd0;
  localparam logic [N_INPUTS-1:0] X_LAST      = '1;
  localparam logic [N_INPUTS-1:0] X_ONE       = 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE_WAIT,
    SAMPLE,
    FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [N_INPUTS-1:0] x_q, x_d;
  logic [3:0]          settle_q, settle_d;
  logic [TT_W-1:0]     tt_q, tt_d;
  logic [N_INPUTS:0]   ones_q, ones_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef TT_SWEEP_COMPARE_EN
  logic                match_q, match_d;
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    settle_d = settle_q;
    tt_d     = tt_q;
    ones_d   = ones_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef TT_SWEEP_COMPARE_EN
    match_d  = match_q;
`endif
    unique case (state_q)
      IDLE: begin
        x_d    = '0;
        busy_d = 1'b0;
        if (bus.start) begin
          tt_d     = '0;
          ones_d   = '0;
          settle_d = '0;
          busy_d   = 1'b1;
`ifdef TT_SWEEP_COMPARE_EN
          match_d  = 1'b0;
`endif
          state_d  = HAS_SETTLE ? SETTLE_WAIT : SAMPLE;
        end
      end
      SETTLE_WAIT: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      SAMPLE: begin
        tt_d[x_q] = bus.f_in;
        ones_d    = ones_q + (N_INPUTS+1)'(bus.f_in);
        // Increment wraps to 0 on the last vector, which is exactly the IDLE value.
        x_d       = x_q + X_ONE;
        if (x_q == X_LAST) begin
          state_d = FINISH;
        end else begin
          state_d = HAS_SETTLE ? SETTLE_WAIT : SAMPLE;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
`ifdef TT_SWEEP_COMPARE_EN
        match_d = (tt_q == bus.expected_tt);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      settle_q <= '0;
      tt_q     <= '0;
      ones_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TT_SWEEP_COMPARE_EN
      match_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      settle_q <= settle_d;
      tt_q     <= tt_d;
      ones_q   <= ones_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef TT_SWEEP_COMPARE_EN
      match_q  <= match_d;
`endif
    end
  end

  assign bus.x_out      = x_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.tt_out     = tt_q;
  assign bus.ones_count = ones_q;
`ifdef TT_SWEEP_COMPARE_EN
  assign bus.match      = match_q;
`endif
endmodule

// File: tb/tb_tt_sweep_capture.sv
// Scoreboard bench for tt_sweep_capture: one instance with SETTLE=0, one with SETTLE=3,
// each driven by a behavioural model of the function under test.
module tb_tt_sweep_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] tt;
    logic [7:0]   ones;
    logic         m;
    int unsigned  due;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int mode0 = 0;
  int mode3 = 4;
  logic [127:0] tbl = 128'hfeeaeae8eeaaaa88eeaaaa88e8a8a880;

  tt_sweep_capture_if #(.N_INPUTS(7)) if0 ();
  tt_sweep_capture_if #(.N_INPUTS(7)) if3 ();

  tt_sweep_capture #(.N_INPUTS(7), .SETTLE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  tt_sweep_capture #(.N_INPUTS(7), .SETTLE(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  function automatic logic fmodel(input int mode, input logic [6:0] x);
    case (mode)
      0:       return x[0];
      1:       return &x;
      2:       return 1'b1;
      3:       return tbl[x];
      4:       return x[6];
      default: return 1'b0;
    endcase
  endfunction

  always_comb if0.f_in = fmodel(mode0, if0.x_out);
  always_comb if3.f_in = fmodel(mode3, if3.x_out);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic on_done(input int sel, input logic [127:0] tt, input logic [7:0] ones,
                         input logic m, input logic busy);
    exp_t e;
    if ((sel == 0 && q0.size() == 0) || (sel == 3 && q3.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL unexpected_done dut=%0d actual=done required=no_done cyc=%0d", sel, cyc);
    end else begin
      e = (sel == 0) ? q0.pop_front() : q3.pop_front();
      chk($sformatf("tt_out_%0d", sel), tt, e.tt);
      chk($sformatf("ones_count_%0d", sel), 128'(ones), 128'(e.ones));
      chk($sformatf("done_cycle_%0d", sel), 128'(cyc), 128'(e.due));
      chk($sformatf("busy_at_done_%0d", sel), 128'(busy), 128'(0));
`ifdef TT_SWEEP_COMPARE_EN
      chk($sformatf("match_%0d", sel), 128'(m), 128'(e.m));
`endif
    end
  endtask

`ifdef TT_SWEEP_COMPARE_EN
  always @(negedge clk) if (rst_n && if0.done) on_done(0, if0.tt_out, if0.ones_count, if0.match, if0.busy);
  always @(negedge clk) if (rst_n && if3.done) on_done(3, if3.tt_out, if3.ones_count, if3.match, if3.busy);
`else
  always @(negedge clk) if (rst_n && if0.done) on_done(0, if0.tt_out, if0.ones_count, 1'b0, if0.busy);
  always @(negedge clk) if (rst_n && if3.done) on_done(3, if3.tt_out, if3.ones_count, 1'b0, if3.busy);
`endif

  // Pulses start for one cycle and records the expected result due TT_W*(SETTLE+1)+1 after E0.
  task automatic kick(input int sel, input logic [127:0] tt, input logic [7:0] ones,
                      input logic m, input int unsigned lat);
    exp_t e;
    @(negedge clk);
    if (sel == 0) if0.start = 1'b1; else if3.start = 1'b1;
    @(negedge clk);
    if (sel == 0) if0.start = 1'b0; else if3.start = 1'b0;
    e.tt = tt; e.ones = ones; e.m = m; e.due = cyc + lat;
    if (sel == 0) q0.push_back(e); else q3.push_back(e);
  endtask

  task automatic drain(input int sel, input int unsigned budget);
    int unsigned n = 0;
    while (((sel == 0) ? q0.size() : q3.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (((sel == 0) ? q0.size() : q3.size()) != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout dut=%0d actual=no_done required=done", sel);
      if (sel == 0) q0.delete(); else q3.delete();
    end
  endtask

  task automatic wait_x0(input logic [6:0] v);
    int unsigned n = 0;
    while (if0.x_out !== v && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vector", 128'(if0.x_out), 128'(v));
  endtask

  initial begin
    logic [127:0] v;
    exp_t e;
    if0.start = 1'b0;
    if3.start = 1'b0;
`ifdef TT_SWEEP_COMPARE_EN
    if0.expected_tt = tbl;
    if3.expected_tt = tbl;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x_out", 128'(if0.x_out), 128'(0));
    chk("rst_busy", 128'(if0.busy), 128'(0));
    chk("rst_done", 128'(if0.done), 128'(0));
    chk("rst_tt_out", if0.tt_out, 128'(0));
    chk("rst_ones", 128'(if0.ones_count), 128'(0));
    chk("rst_busy3", 128'(if3.busy), 128'(0));
`ifdef TT_SWEEP_COMPARE_EN
    chk("rst_match", 128'(if0.match), 128'(0));
`endif
    rst_n = 1'b1;

    mode0 = 0;
    kick(0, {64{2'b10}}, 8'd64, 1'b0, 129);
    drain(0, 300);

    mode0 = 1;
    v = '0; v[127] = 1'b1;
    kick(0, v, 8'd1, 1'b0, 129);
    drain(0, 300);

    mode0 = 2;
    kick(0, '1, 8'd128, 1'b0, 129);
    drain(0, 300);

    mode0 = 3;
    kick(0, tbl, 8'($countones(tbl)), 1'b1, 129);
    drain(0, 300);
`ifdef TT_SWEEP_COMPARE_EN
    v = tbl; v[7] = ~v[7];
    if0.expected_tt = v;
`endif
    kick(0, tbl, 8'($countones(tbl)), 1'b0, 129);
    drain(0, 300);

    // SETTLE=3: each vector held for four cycles.
    mode3 = 4;
    kick(3, {{64{1'b1}}, {64{1'b0}}}, 8'd64, 1'b0, 513);
    for (int i = 0; i < 12; i++) begin
      chk("x_hold", 128'(if3.x_out), 128'(i / 4));
      @(negedge clk);
    end
    drain(3, 700);

    // start during busy is ignored.
    mode0 = 0;
    kick(0, {64{2'b10}}, 8'd64, 1'b0, 129);
    wait_x0(7'd40);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    drain(0, 300);
    repeat (150) @(negedge clk);

    // start held high: back-to-back sweeps, busy low only in the done cycle.
    mode0 = 2;
    @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    e.tt = '1; e.ones = 8'd128; e.m = 1'b0;
    e.due = cyc + 129; q0.push_back(e);
    e.due = cyc + 130 + 129; q0.push_back(e);
    repeat (129) @(negedge clk);
    chk("held_busy_done_cycle", 128'(if0.busy), 128'(0));
    @(negedge clk);
    chk("held_busy_restart", 128'(if0.busy), 128'(1));
    if0.start = 1'b0;
    drain(0, 300);

    // Reset mid-sweep: no done, all reset values, then a clean sweep.
    mode0 = 0;
    kick(0, {64{2'b10}}, 8'd64, 1'b0, 129);
    wait_x0(7'd70);
    rst_n = 1'b0;
    q0.delete();
    @(negedge clk);
    chk("midrst_x_out", 128'(if0.x_out), 128'(0));
    chk("midrst_busy", 128'(if0.busy), 128'(0));
    chk("midrst_tt_out", if0.tt_out, 128'(0));
    chk("midrst_ones", 128'(if0.ones_count), 128'(0));
    chk("midrst_done", 128'(if0.done), 128'(0));
    rst_n = 1'b1;
    repeat (140) @(negedge clk);
    mode0 = 1;
    v = '0; v[127] = 1'b1;
    kick(0, v, 8'd1, 1'b0, 129);
    drain(0, 300);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tt_sweep_capture.md
# tt_sweep_capture

Sequential truth-table extractor placed directly upstream and downstream of a 7-input combinational classification function. It drives every input vector 0..2^N-1 onto the function's inputs, samples the single-bit output, and assembles the full truth table plus its on-set weight. A start/busy/done handshake makes the extracted table available to the classification and bookkeeping logic.

## Interface
- N_INPUTS, 7, number of function inputs; truth table width TT_W = 2^N_INPUTS
- SETTLE, 0, extra idle cycles per vector before sampling f_in (0..15); covers multi-cycle function paths
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  sweep request; sampled only in IDLE
- f_in  input  1  output of the function under test, combinational from x_out
- x_out  output  N_INPUTS  current input vector; drives x0 (LSB) .. x6 (MSB)
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when tt_out and ones_count are final
- tt_out  output  TT_W  captured table; tt_out[k] = f(x_out = k)
- ones_count  output  N_INPUTS+1  number of 1 bits in tt_out (0..TT_W)
- expected_tt  input  TT_W  reference table (present only with TT_SWEEP_COMPARE_EN)
- match  output  1  tt_out == expected_tt, valid with done (present only with TT_SWEEP_COMPARE_EN)

## Operation
- States: IDLE, SETTLE_WAIT, SAMPLE, FINISH.
- IDLE: x_out = 0, busy = 0. When start = 1: clear tt_out, ones_count and the vector counter, then go to SETTLE_WAIT if SETTLE > 0, else SAMPLE.
- SETTLE_WAIT: hold x_out for SETTLE cycles, then go to SAMPLE.
- SAMPLE: on the clock edge, write f_in into tt_out[x_out] and add f_in to ones_count.
  - If x_out = TT_W-1: go to FINISH.
  - Otherwise increment x_out and go to SETTLE_WAIT, or stay in SAMPLE if SETTLE = 0.
- FINISH: assert done for exactly one cycle, drop busy, return to IDLE. tt_out and ones_count hold until the next accepted start.
- start is ignored outside IDLE; it is not queued.
- start held high continuously: a new sweep begins the cycle after FINISH.
- Width rules:
  - The counter is N_INPUTS bits. Completion is detected on the terminal value, never on wrap-around to 0.
  - ones_count is N_INPUTS+1 bits, so TT_W (128) is representable without overflow.
- f_in is sampled only in SAMPLE; glitches during SETTLE_WAIT have no effect.

## Timing
- All outputs are registered.
- Reset values: x_out = 0, busy = 0, done = 0, tt_out = 0, ones_count = 0, match = 0; state = IDLE.
- start accepted at edge E0. busy is 1 and x_out = 0 from E0.
- Vector k is presented for SETTLE+1 cycles and sampled at the last of those edges.
- Sweep length is TT_W*(SETTLE+1) cycles. The done pulse is in the cycle after the final sample, at edge E0 + TT_W*(SETTLE+1) + 1. For N=7, SETTLE=0 that is 129 cycles after E0.
- Back-to-back sweeps: the minimum gap between done pulses is TT_W*(SETTLE+1)+2 cycles.
- rst_n low on any edge, including mid-sweep, returns to IDLE with all reset values on that edge. A partial table is never reported and no done is produced.

## Configuration
- TT_SWEEP_COMPARE_EN defined:
  - The expected_tt input and match output exist.
  - match is registered in FINISH as (tt_out with the final sample included) == expected_tt, so it is valid in the done cycle.
  - match holds until the next accepted start or reset.
- Not defined: neither port exists and no comparator is synthesized. All other behaviour is identical.

## Test plan
- Reset, then f_in tied to x_out[0]; pulse start -> done 129 cycles later; tt_out = 0xAAAA…AAAA (128 bits); ones_count = 64.
- f_in = AND of all seven x bits -> tt_out = 1<<127, ones_count = 1. f_in constant 1 -> tt_out all ones, ones_count = 128.
- f_in driven by the 7-input majority network under classification, expected_tt = 0xfeeaeae8eeaaaa88eeaaaa88e8a8a880 with TT_SWEEP_COMPARE_EN -> match = 1 with done. Flip expected bit 0x80's position -> match = 0.
- SETTLE = 3; f_in = x_out[6] -> done 513 cycles after start; tt_out upper 64 bits 1, lower 64 bits 0; each x_out value held 4 cycles.
- start re-asserted during busy at vector 40 -> ignored, single done. start held high -> second sweep begins the cycle after done, busy low for exactly the done cycle.
- rst_n low at vector 70 -> next cycle x_out = 0, busy = 0, tt_out = 0, no done; new start yields a correct full table.
